// File: rtl/axi_lite_master_port.sv
// AXI4-Lite initiator: turns one core load/store request at a time into
// an AXI4-Lite read or write and returns read data plus error status.
//
// Ports:
//   CLK, RSTn            clock (rising edge), async active-low reset
//   req_*                core request (valid/ready, we, addr, wdata, wstrb)
//   rsp_*                one-cycle completion pulse, read data, error flag
//   M_AXI_AW*/W*/B*      AXI4-Lite write address / data / response
//   M_AXI_AR*/R*         AXI4-Lite read address / data
//
// Build option: AXI_MASTER_ALIGN_CHECK_EN
//   defined   - misaligned requests complete at once with rsp_err=1 and
//               generate no AXI traffic
//   undefined - address low bits are forced to zero (core pre-aligns)

module axi_lite_master_port #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [2:0]  AXI_PROT   = 3'b000
) (
    input  logic                    CLK,
    input  logic                    RSTn,

    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,

    output logic                    M_AXI_AWVALID,
    input  logic                    M_AXI_AWREADY,
    output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]              M_AXI_AWPROT,

    output logic                    M_AXI_WVALID,
    input  logic                    M_AXI_WREADY,
    output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,

    input  logic                    M_AXI_BVALID,
    output logic                    M_AXI_BREADY,
    input  logic [1:0]              M_AXI_BRESP,

    output logic                    M_AXI_ARVALID,
    input  logic                    M_AXI_ARREADY,
    output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]              M_AXI_ARPROT,

    input  logic                    M_AXI_RVALID,
    output logic                    M_AXI_RREADY,
    input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]              M_AXI_RRESP
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned OFF_W  = $clog2(STRB_W);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_ADDR = 3'd1,
        S_RD_DATA = 3'd2,
        S_WR_REQ  = 3'd3,
        S_WR_RESP = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t                  r_state;
    state_t                  w_next;

    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [STRB_W-1:0]       r_wstrb;
    logic                    r_aw_done;
    logic                    r_w_done;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    r_err;

    logic                    w_accept;
    logic                    w_misalign;
    logic [ADDR_WIDTH-1:0]   w_req_addr;
    logic                    w_aw_hs;
    logic                    w_w_hs;
    logic                    w_b_hs;
    logic                    w_r_hs;
    logic                    w_aw_fin;
    logic                    w_w_fin;

`ifdef AXI_MASTER_ALIGN_CHECK_EN
    logic [OFF_W-1:0]        w_off;

    assign w_off = req_addr[OFF_W-1:0];

    // A write is misaligned only if its strobes, moved to the byte
    // offset, would spill past the end of the word.
    assign w_misalign = (w_off != '0) &&
                        (!req_we ||
                         (((({{STRB_W{1'b0}}, req_wstrb}) << w_off)
                           >> STRB_W) != '0));

    assign w_req_addr = req_addr;
`else
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK =
        ~(ADDR_WIDTH'(STRB_W - 1));

    assign w_misalign = 1'b0;
    assign w_req_addr = req_addr & ADDR_MASK;
`endif

    assign w_accept = req_valid & req_ready;
    assign w_aw_hs  = M_AXI_AWVALID & M_AXI_AWREADY;
    assign w_w_hs   = M_AXI_WVALID  & M_AXI_WREADY;
    assign w_b_hs   = M_AXI_BVALID  & M_AXI_BREADY;
    assign w_r_hs   = M_AXI_RVALID  & M_AXI_RREADY;

    // AW and W complete independently, in any order or together.
    assign w_aw_fin = r_aw_done | w_aw_hs;
    assign w_w_fin  = r_w_done  | w_w_hs;

    // State register
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (w_misalign) begin
                        w_next = S_DONE;
                    end else if (req_we) begin
                        w_next = S_WR_REQ;
                    end else begin
                        w_next = S_RD_ADDR;
                    end
                end
            end
            S_RD_ADDR: begin
                if (M_AXI_ARREADY) begin
                    w_next = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (M_AXI_RVALID) begin
                    w_next = S_DONE;
                end
            end
            S_WR_REQ: begin
                if (w_aw_fin && w_w_fin) begin
                    w_next = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                if (M_AXI_BVALID) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Output decode; every handshake signal comes straight from the
    // state register and the done flags, so nothing combinational from
    // the AXI inputs reaches the outputs.
    always_comb begin
        req_ready     = 1'b0;
        rsp_valid     = 1'b0;
        M_AXI_ARVALID = 1'b0;
        M_AXI_RREADY  = 1'b0;
        M_AXI_AWVALID = 1'b0;
        M_AXI_WVALID  = 1'b0;
        M_AXI_BREADY  = 1'b0;
        unique case (r_state)
            S_IDLE:    req_ready     = 1'b1;
            S_RD_ADDR: M_AXI_ARVALID = 1'b1;
            S_RD_DATA: M_AXI_RREADY  = 1'b1;
            S_WR_REQ: begin
                M_AXI_AWVALID = ~r_aw_done;
                M_AXI_WVALID  = ~r_w_done;
            end
            S_WR_RESP: M_AXI_BREADY  = 1'b1;
            S_DONE:    rsp_valid     = 1'b1;
            default:   ;
        endcase
    end

    // Request capture, write-channel progress and response capture
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr    <= w_req_addr;
                r_wdata   <= req_wdata;
                r_wstrb   <= req_wstrb;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
                r_err     <= w_misalign;
            end
            if (w_aw_hs) begin
                r_aw_done <= 1'b1;
            end
            if (w_w_hs) begin
                r_w_done <= 1'b1;
            end
            if (w_r_hs) begin
                r_rdata <= M_AXI_RDATA;
                r_err   <= (M_AXI_RRESP != 2'b00);
            end
            if (w_b_hs) begin
                r_err <= (M_AXI_BRESP != 2'b00);
            end
        end
    end

    // Read and write never overlap, so one address register serves both.
    assign M_AXI_AWADDR = r_addr;
    assign M_AXI_ARADDR = r_addr;
    assign M_AXI_AWPROT = AXI_PROT;
    assign M_AXI_ARPROT = AXI_PROT;
    assign M_AXI_WDATA  = r_wdata;
    assign M_AXI_WSTRB  = r_wstrb;
    assign rsp_rdata    = r_rdata;
    assign rsp_err      = r_err;

endmodule

// File: tb/tb_axi_lite_master_port.sv
// Self-checking bench for axi_lite_master_port: table of directed
// transactions against a delay-configurable AXI4-Lite responder.

module tb_axi_lite_master_port;

    logic        CLK;
    logic        RSTn;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        M_AXI_AWVALID;
    logic        M_AXI_AWREADY;
    logic [31:0] M_AXI_AWADDR;
    logic [2:0]  M_AXI_AWPROT;
    logic        M_AXI_WVALID;
    logic        M_AXI_WREADY;
    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_BVALID;
    logic        M_AXI_BREADY;
    logic [1:0]  M_AXI_BRESP;
    logic        M_AXI_ARVALID;
    logic        M_AXI_ARREADY;
    logic [31:0] M_AXI_ARADDR;
    logic [2:0]  M_AXI_ARPROT;
    logic        M_AXI_RVALID;
    logic        M_AXI_RREADY;
    logic [31:0] M_AXI_RDATA;
    logic [1:0]  M_AXI_RRESP;

    axi_lite_master_port dut (
        .CLK           (CLK),
        .RSTn          (RSTn),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_wstrb     (req_wstrb),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .M_AXI_AWVALID (M_AXI_AWVALID),
        .M_AXI_AWREADY (M_AXI_AWREADY),
        .M_AXI_AWADDR  (M_AXI_AWADDR),
        .M_AXI_AWPROT  (M_AXI_AWPROT),
        .M_AXI_WVALID  (M_AXI_WVALID),
        .M_AXI_WREADY  (M_AXI_WREADY),
        .M_AXI_WDATA   (M_AXI_WDATA),
        .M_AXI_WSTRB   (M_AXI_WSTRB),
        .M_AXI_BVALID  (M_AXI_BVALID),
        .M_AXI_BREADY  (M_AXI_BREADY),
        .M_AXI_BRESP   (M_AXI_BRESP),
        .M_AXI_ARVALID (M_AXI_ARVALID),
        .M_AXI_ARREADY (M_AXI_ARREADY),
        .M_AXI_ARADDR  (M_AXI_ARADDR),
        .M_AXI_ARPROT  (M_AXI_ARPROT),
        .M_AXI_RVALID  (M_AXI_RVALID),
        .M_AXI_RREADY  (M_AXI_RREADY),
        .M_AXI_RDATA   (M_AXI_RDATA),
        .M_AXI_RRESP   (M_AXI_RRESP)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          ard;
        int          rd;
        int          awd;
        int          wd;
        int          bd;
        logic        early;
        logic [1:0]  resp;
        logic [31:0] rdata;
        int          lat;
        logic        err;
        logic [31:0] exp_rdata;
        logic [31:0] exp_addr;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // responder configuration
    int          cfg_ard, cfg_rd, cfg_awd, cfg_wd, cfg_bd;
    logic        cfg_early;
    logic [1:0]  cfg_resp;
    logic [31:0] cfg_rdata;

    // responder state and logs
    int          ar_wait, aw_wait, w_wait, r_wait, b_wait;
    logic        r_pend, b_pend, aw_got, w_got;
    int          n_ar, n_aw, n_w, prot_err;
    logic [31:0] ar_log[$];
    logic [31:0] last_awaddr, last_wdata;
    logic [3:0]  last_wstrb;
    logic        p_arv, p_arr, p_awv, p_awr, p_wv, p_wr;
    logic [31:0] p_araddr, p_awaddr, p_wdata;
    logic [3:0]  p_wstrb;

    initial begin
        n_ar = 0; n_aw = 0; n_w = 0; prot_err = 0;
        cfg_ard = 0; cfg_rd = 0; cfg_awd = 0; cfg_wd = 0; cfg_bd = 0;
        cfg_early = 0; cfg_resp = 0; cfg_rdata = 0;
    end

    // Responder: every decision is taken at the falling edge, so a
    // handshake seen here happens at the following rising edge.
    always @(negedge CLK) begin
        if (!RSTn) begin
            M_AXI_ARREADY = 0; M_AXI_AWREADY = 0; M_AXI_WREADY = 0;
            M_AXI_RVALID = 0; M_AXI_BVALID = 0;
            M_AXI_RDATA = 32'hBAADF00D; M_AXI_RRESP = 2'b11;
            M_AXI_BRESP = 2'b11;
            ar_wait = 0; aw_wait = 0; w_wait = 0; r_wait = 0; b_wait = 0;
            r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
            p_arv = 0; p_arr = 0; p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0;
            p_araddr = 0; p_awaddr = 0; p_wdata = 0; p_wstrb = 0;
        end else begin
            if (p_arv && !p_arr &&
                (!M_AXI_ARVALID || M_AXI_ARADDR !== p_araddr))
                prot_err++;
            if (p_awv && !p_awr &&
                (!M_AXI_AWVALID || M_AXI_AWADDR !== p_awaddr))
                prot_err++;
            if (p_wv && !p_wr &&
                (!M_AXI_WVALID || M_AXI_WDATA !== p_wdata ||
                 M_AXI_WSTRB !== p_wstrb))
                prot_err++;
            if (M_AXI_ARVALID && (M_AXI_AWVALID || M_AXI_WVALID))
                prot_err++;

            if (b_pend && b_wait >= cfg_bd) begin
                M_AXI_BVALID = 1; M_AXI_BRESP = cfg_resp;
                if (M_AXI_BREADY) b_pend = 0;
            end else begin
                M_AXI_BVALID = 0; M_AXI_BRESP = 2'b11;
                if (b_pend) b_wait++;
            end

            if (r_pend && r_wait >= cfg_rd) begin
                M_AXI_RVALID = 1; M_AXI_RRESP = cfg_resp;
                M_AXI_RDATA = cfg_rdata;
                if (M_AXI_RREADY) r_pend = 0;
            end else begin
                M_AXI_RVALID = 0; M_AXI_RRESP = 2'b11;
                M_AXI_RDATA = 32'hBAADF00D;
                if (r_pend) r_wait++;
            end

            if (cfg_early) M_AXI_AWREADY = 1;
            else M_AXI_AWREADY = M_AXI_AWVALID && (aw_wait >= cfg_awd);
            if (M_AXI_AWVALID) begin
                if (M_AXI_AWREADY) begin
                    n_aw++; aw_got = 1; last_awaddr = M_AXI_AWADDR;
                end else aw_wait++;
            end else aw_wait = 0;

            if (cfg_early) M_AXI_WREADY = 1;
            else M_AXI_WREADY = M_AXI_WVALID && (w_wait >= cfg_wd);
            if (M_AXI_WVALID) begin
                if (M_AXI_WREADY) begin
                    n_w++; w_got = 1;
                    last_wdata = M_AXI_WDATA; last_wstrb = M_AXI_WSTRB;
                end else w_wait++;
            end else w_wait = 0;

            if (aw_got && w_got) begin
                b_pend = 1; b_wait = 0; aw_got = 0; w_got = 0;
            end

            if (cfg_early) M_AXI_ARREADY = 1;
            else M_AXI_ARREADY = M_AXI_ARVALID && (ar_wait >= cfg_ard);
            if (M_AXI_ARVALID) begin
                if (M_AXI_ARREADY) begin
                    n_ar++; ar_log.push_back(M_AXI_ARADDR);
                    r_pend = 1; r_wait = 0;
                end else ar_wait++;
            end else ar_wait = 0;

            p_arv = M_AXI_ARVALID; p_arr = M_AXI_ARREADY;
            p_araddr = M_AXI_ARADDR;
            p_awv = M_AXI_AWVALID; p_awr = M_AXI_AWREADY;
            p_awaddr = M_AXI_AWADDR;
            p_wv = M_AXI_WVALID; p_wr = M_AXI_WREADY;
            p_wdata = M_AXI_WDATA; p_wstrb = M_AXI_WSTRB;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int   lat;
        int   ar0, aw0, w0, pe0;
        logic traffic;
        @(negedge CLK);
        chk($sformatf("v%0d_idle_ready", id), 32'(req_ready), 32'd1);
        cfg_ard = v.ard; cfg_rd = v.rd; cfg_awd = v.awd;
        cfg_wd = v.wd; cfg_bd = v.bd; cfg_early = v.early;
        cfg_resp = v.resp; cfg_rdata = v.rdata;
        ar0 = n_ar; aw0 = n_aw; w0 = n_w; pe0 = prot_err;
        req_valid = 1; req_we = v.we; req_addr = v.addr;
        req_wdata = v.wdata; req_wstrb = v.wstrb;
        @(posedge CLK);
        @(negedge CLK);
        req_valid = 0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            @(posedge CLK);
            @(negedge CLK);
            lat++;
        end
        chk($sformatf("v%0d_latency", id), 32'(lat), 32'(v.lat));
        chk($sformatf("v%0d_err", id), 32'(rsp_err), 32'(v.err));
        chk($sformatf("v%0d_rdata", id), rsp_rdata, v.exp_rdata);
        @(posedge CLK);
        @(negedge CLK);
        chk($sformatf("v%0d_pulse", id), {30'd0, rsp_valid, req_ready},
            32'd1);
        traffic = (v.lat != 1);
        chk($sformatf("v%0d_n_ar", id), 32'(n_ar - ar0),
            32'(!v.we && traffic));
        chk($sformatf("v%0d_n_aw", id), 32'(n_aw - aw0),
            32'(v.we && traffic));
        chk($sformatf("v%0d_n_w", id), 32'(n_w - w0),
            32'(v.we && traffic));
        chk($sformatf("v%0d_protocol", id), 32'(prot_err - pe0), 32'd0);
        if (traffic && !v.we && ar_log.size() > 0)
            chk($sformatf("v%0d_araddr", id), ar_log[ar_log.size()-1],
                v.exp_addr);
        if (traffic && v.we) begin
            chk($sformatf("v%0d_awaddr", id), last_awaddr, v.exp_addr);
            chk($sformatf("v%0d_wdata", id), last_wdata, v.wdata);
            chk($sformatf("v%0d_wstrb", id), 32'(last_wstrb),
                32'(v.wstrb));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tv[10];
        vec_t        rv;
        int          ar0, pe0, qsz;
        logic [7:0]  rdy_pat, rsp_pat;

        //        we    addr        wdata         strb  ard rd awd wd bd
        //        early resp  rdata         lat err exp_rdata    exp_addr
        tv[0] = '{1'b0, 32'h10, 32'h0, 4'h0, 0, 0, 0, 0, 0,
                  1'b0, 2'b00, 32'hDEADBEEF, 3, 1'b0, 32'hDEADBEEF, 32'h10};
        tv[1] = '{1'b1, 32'h20, 32'h12345678, 4'b0011, 0, 0, 0, 3, 0,
                  1'b0, 2'b00, 32'h0, 6, 1'b0, 32'hDEADBEEF, 32'h20};
        tv[2] = '{1'b0, 32'h30, 32'h0, 4'h0, 0, 0, 0, 0, 0,
                  1'b0, 2'b10, 32'hBAD0BAD0, 3, 1'b1, 32'hBAD0BAD0, 32'h30};
        tv[3] = '{1'b0, 32'h40, 32'h0, 4'h0, 2, 1, 0, 0, 0,
                  1'b0, 2'b00, 32'h00001111, 6, 1'b0, 32'h00001111, 32'h40};
        tv[4] = '{1'b1, 32'h44, 32'hA5A5A5A5, 4'b1111, 0, 0, 3, 0, 2,
                  1'b0, 2'b11, 32'h0, 8, 1'b1, 32'h00001111, 32'h44};
        tv[5] = '{1'b1, 32'h48, 32'hCAFEF00D, 4'b1100, 0, 0, 0, 0, 0,
                  1'b1, 2'b00, 32'h0, 3, 1'b0, 32'h00001111, 32'h48};
`ifdef AXI_MASTER_ALIGN_CHECK_EN
        tv[6] = '{1'b0, 32'h13, 32'h0, 4'h0, 0, 0, 0, 0, 0,
                  1'b1, 2'b00, 32'h55AA55AA, 1, 1'b1, 32'h00001111, 32'h0};
`else
        tv[6] = '{1'b0, 32'h13, 32'h0, 4'h0, 0, 0, 0, 0, 0,
                  1'b1, 2'b00, 32'h55AA55AA, 3, 1'b0, 32'h55AA55AA, 32'h10};
`endif
        tv[7] = '{1'b0, 32'h7C, 32'h0, 4'h0, 1, 0, 0, 0, 0,
                  1'b0, 2'b01, 32'h0F0F0F0F, 4, 1'b1, 32'h0F0F0F0F, 32'h7C};
        tv[8] = '{1'b1, 32'h50, 32'h11223344, 4'b0001, 0, 0, 2, 2, 1,
                  1'b0, 2'b00, 32'h0, 6, 1'b0, 32'h0F0F0F0F, 32'h50};
`ifdef AXI_MASTER_ALIGN_CHECK_EN
        tv[9] = '{1'b1, 32'h2E, 32'h0000BEEF, 4'b0011, 0, 0, 0, 0, 0,
                  1'b0, 2'b00, 32'h0, 3, 1'b0, 32'h0F0F0F0F, 32'h2E};
`else
        tv[9] = '{1'b1, 32'h2E, 32'h0000BEEF, 4'b0011, 0, 0, 0, 0, 0,
                  1'b0, 2'b00, 32'h0, 3, 1'b0, 32'h0F0F0F0F, 32'h2C};
`endif

        RSTn = 0; req_valid = 0; req_we = 0; req_addr = 0;
        req_wdata = 0; req_wstrb = 0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_handshakes",
            {25'd0, M_AXI_ARVALID, M_AXI_AWVALID, M_AXI_WVALID,
             M_AXI_RREADY, M_AXI_BREADY, rsp_valid, rsp_err}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_araddr", M_AXI_ARADDR, 32'd0);
        chk("rst_awaddr", M_AXI_AWADDR, 32'd0);
        chk("rst_wdata", M_AXI_WDATA, 32'd0);
        chk("rst_wstrb", 32'(M_AXI_WSTRB), 32'd0);
        chk("prot", {26'd0, M_AXI_ARPROT, M_AXI_AWPROT}, 32'd0);
        #11;
        RSTn = 1;

        for (int i = 0; i < 10; i++) run_vec(tv[i], i);

        // Back-to-back reads with req_valid held high
        @(negedge CLK);
        cfg_ard = 0; cfg_rd = 0; cfg_awd = 0; cfg_wd = 0; cfg_bd = 0;
        cfg_early = 0; cfg_resp = 2'b00; cfg_rdata = 32'h13579BDF;
        ar0 = n_ar; pe0 = prot_err; qsz = ar_log.size();
        req_valid = 1; req_we = 0; req_addr = 32'h60;
        rdy_pat = 0; rsp_pat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge CLK);
            @(negedge CLK);
            rdy_pat[k-1] = req_ready;
            rsp_pat[k-1] = rsp_valid;
            if (k == 1) req_addr = 32'h64;
            if (k == 5) req_valid = 0;
        end
        chk("b2b_ready_pattern", 32'(rdy_pat), 32'h88);
        chk("b2b_rsp_pattern", 32'(rsp_pat), 32'h44);
        chk("b2b_n_ar", 32'(n_ar - ar0), 32'd2);
        chk("b2b_araddr0",
            (ar_log.size() > qsz) ? ar_log[qsz] : 32'hFFFFFFFF, 32'h60);
        chk("b2b_araddr1",
            (ar_log.size() > qsz + 1) ? ar_log[qsz+1] : 32'hFFFFFFFF,
            32'h64);
        chk("b2b_rdata", rsp_rdata, 32'h13579BDF);
        chk("b2b_protocol", 32'(prot_err - pe0), 32'd0);

        // Asynchronous reset while waiting for read data
        @(negedge CLK);
        cfg_rd = 6; cfg_rdata = 32'h0;
        req_valid = 1; req_we = 0; req_addr = 32'h70;
        @(posedge CLK);
        @(negedge CLK);
        req_valid = 0;
        @(posedge CLK);
        @(negedge CLK);
        chk("pre_rst_rready", 32'(M_AXI_RREADY), 32'd1);
        #2;
        RSTn = 0;
        #1;
        chk("arst_req_ready", 32'(req_ready), 32'd1);
        chk("arst_handshakes",
            {25'd0, M_AXI_ARVALID, M_AXI_AWVALID, M_AXI_WVALID,
             M_AXI_RREADY, M_AXI_BREADY, rsp_valid, rsp_err}, 32'd0);
        chk("arst_rdata", rsp_rdata, 32'd0);
        chk("arst_araddr", M_AXI_ARADDR, 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        #2;
        RSTn = 1;
        rv = '{1'b0, 32'h84, 32'h0, 4'h0, 0, 0, 0, 0, 0,
               1'b0, 2'b00, 32'h600DF00D, 3, 1'b0, 32'h600DF00D, 32'h84};
        run_vec(rv, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_lite_master_port.md
Name: axi_lite_master_port

Overview:
AXI4-Lite initiator that turns the CPU's single-outstanding load/store request into AXI4-Lite read or write transactions toward memory or peripherals. It is the master end facing the memory-side AXI4-Lite responder. It sits between the core's memory stage and the M_AXI_* port bundle of riscv_cpu. It handles one transaction at a time and returns read data and response status to the core.

Parameters:
ADDR_WIDTH, 32, AXI/request address width
DATA_WIDTH, 32, AXI/request data width; strobe width = DATA_WIDTH/8
AXI_PROT, 3'b000, constant driven on AWPROT/ARPROT

Ports:
CLK  input  1  clock, all logic on rising edge
RSTn  input  1  reset, asynchronous, active-low
req_valid  input  1  core requests a transaction
req_ready  output  1  block idle, request accepted when req_valid&req_ready
req_we  input  1  1=write, 0=read
req_addr  input  ADDR_WIDTH  byte address
req_wdata  input  DATA_WIDTH  write data
req_wstrb  input  DATA_WIDTH/8  byte enables for writes
rsp_valid  output  1  one-cycle pulse, transaction complete
rsp_rdata  output  DATA_WIDTH  read data, valid with rsp_valid on reads
rsp_err  output  1  response was SLVERR/DECERR (or misaligned, see option)
M_AXI_AWVALID/AWREADY/AWADDR/AWPROT  out/in/out/out  1/1/ADDR_WIDTH/3  write address channel
M_AXI_WVALID/WREADY/WDATA/WSTRB  out/in/out/out  1/1/DATA_WIDTH/DATA_WIDTH/8  write data channel
M_AXI_BVALID/BREADY/BRESP  in/out/in  1/1/2  write response channel
M_AXI_ARVALID/ARREADY/ARADDR/ARPROT  out/in/out/out  1/1/ADDR_WIDTH/3  read address channel
M_AXI_RVALID/RREADY/RDATA/RRESP  in/out/in/in  1/1/DATA_WIDTH/2  read data channel

Behaviour:
- Reset (RSTn low, async): state IDLE; req_ready=1; rsp_valid=0, rsp_rdata=0, rsp_err=0; all AXI VALID/READY outputs 0; AWADDR/ARADDR/WDATA/WSTRB=0. Outstanding AXI transaction is abandoned; the system resets the slave together with the master.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE: req_ready=1. On accept, register addr/wdata/wstrb. req_we=0 goes to RD_ADDR; req_we=1 goes to WR_REQ. VALIDs are asserted from the next cycle, fully registered.
- RD_ADDR: ARVALID=1, ARADDR stable until ARREADY. On handshake, ARVALID drops and the state goes to RD_DATA.
- RD_DATA: RREADY=1 until RVALID. On handshake, capture RDATA and set rsp_err=(RRESP!=2'b00). Go to DONE.
- WR_REQ: AWVALID and WVALID are asserted together. Each drops independently after its own handshake, tracked by aw_done/w_done flags. Both handshakes may occur in the same cycle or in either order. When both are done, go to WR_RESP.
- WR_RESP: BREADY=1 until BVALID. On handshake, rsp_err=(BRESP!=2'b00). Go to DONE.
- DONE: rsp_valid=1 for exactly one cycle, then IDLE. req_ready=0 in every non-IDLE state.
- No VALID deasserts before its READY. Address, data and strobe are stable while VALID is high.
- rsp_rdata holds its last read value until the next read completes. Writes do not change it.
- Latency with a zero-wait slave: read accepted at cycle N, AR handshake N+1, R handshake N+2, rsp_valid N+3. Writes have the same latency with AW/W at N+1 and B at N+2.
- A READY asserted before VALID is legal and is ignored until VALID is high.

Optional Feature:
AXI_MASTER_ALIGN_CHECK_EN
- Defined: a request is misaligned if req_addr[1:0]!=0 and the set bits of req_wstrb (writes) do not fit within the word. A misaligned read is any read with req_addr[1:0]!=0. A misaligned request issues no AXI traffic and goes directly to DONE with rsp_err=1, so rsp_valid occurs at N+1.
- Undefined: the address is passed through unchecked. The core must pre-align; a word-aligned ARADDR/AWADDR is driven with the low 2 bits forced to 0.

Test Plan:
- Read, zero-wait slave, addr 0x10, RDATA=0xDEADBEEF, RRESP=00 -> ARADDR=0x10 at N+1; rsp_valid pulse at N+3; rsp_rdata=0xDEADBEEF; rsp_err=0.
- Write addr 0x20, wdata 0x12345678, wstrb 4'b0011; WREADY 3 cycles after AWREADY -> AWVALID drops after its handshake; WVALID is held with stable data until WREADY; BREADY then rises; rsp_valid 1 cycle after the B handshake.
- Read with RRESP=2'b10 (SLVERR) -> rsp_err=1 with rsp_valid; the next good read clears rsp_err to 0.
- Back-to-back requests (req_valid held high) -> req_ready=0 from accept until the cycle after rsp_valid; the second request is accepted only in IDLE; no AXI VALID overlap between transactions.
- RSTn low while in RD_DATA -> all outputs go to reset values immediately (asynchronously); after release, req_ready=1 and the next read completes normally.
- With AXI_MASTER_ALIGN_CHECK_EN defined: read at 0x22 -> no ARVALID; rsp_valid at N+1 with rsp_err=1.
